pgr_apb_burst_ctr: RTL

Parametrised UART-byte-stream to APB master command engine with burst transfers, address auto-increment, per-beat timeout and a status byte on every frame. It sits between the byte FIFOs of the UART core and the APB slave fabric. It replaces the fixed 32-bit/16-bit-address controller in new UART-to-APB bridge tops.

---
 rtl/pgr_apb_burst_ctr_if.sv | 33 +++
 rtl/pgr_apb_burst_ctr.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pgr_apb_burst_ctr_if.sv
// rtl/pgr_apb_burst_ctr_if.sv - byte-FIFO and APB bus bundle for the UART-to-APB burst controller
`timescale 1ns/1ps
interface pgr_apb_burst_ctr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic [7:0]          rx_fifo_rd_data;
  logic                rx_fifo_rd_data_valid;
  logic                rx_fifo_rd_data_req;
  logic [7:0]          tx_fifo_wr_data;
  logic                tx_fifo_wr_data_valid;
  logic                tx_fifo_wr_data_req;
  logic                p_sel;
  logic                p_ce;
  logic                p_we;
  logic [ADDR_W-1:0]   p_addr;
  logic [DATA_W-1:0]   p_wdata;
  logic [DATA_W/8-1:0] p_strb;
  logic                p_rdy;
  logic [DATA_W-1:0]   p_rdata;

  modport master (
    input  rx_fifo_rd_data, rx_fifo_rd_data_valid, tx_fifo_wr_data_req, p_rdy, p_rdata,
    output rx_fifo_rd_data_req, tx_fifo_wr_data, tx_fifo_wr_data_valid,
           p_sel, p_ce, p_we, p_addr, p_wdata, p_strb
  );

  modport slave (
    output rx_fifo_rd_data, rx_fifo_rd_data_valid, tx_fifo_wr_data_req, p_rdy, p_rdata,
    input  rx_fifo_rd_data_req, tx_fifo_wr_data, tx_fifo_wr_data_valid,
           p_sel, p_ce, p_we, p_addr, p_wdata, p_strb
  );
endinterface

// File: rtl/pgr_apb_burst_ctr.sv
// rtl/pgr_apb_burst_ctr.sv - UART byte stream to APB burst master with status byte per frame
// Optional per-beat ACCESS timeout and write-data drain: define PGR_APB_CTR_TIMEOUT_EN.
`timescale 1ns/1ps
module pgr_apb_burst_ctr #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pgr_apb_burst_ctr_if.master  bus
);
  localparam int BYTES  = DATA_W / 8;
  localparam int ABYTES = ADDR_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_RDTX,
    S_STATUS
`ifdef PGR_APB_CTR_TIMEOUT_EN
    ,
    S_DRAIN
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                active_q;
  logic                is_wr_q;
  logic [6:0]          beats_q;
  logic [3:0]          byte_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rx_req;
  logic                rx_take;
  logic                tx_take;
  logic                last_abyte;
  logic                last_dbyte;
  logic [7:0]          status_byte;

`ifdef PGR_APB_CTR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]     to_cnt_q;
  logic [10:0]         drain_q;
  logic                err_q;
  logic                timeout;

  assign timeout     = (state_q == S_ACCESS) && !bus.p_rdy && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign status_byte = err_q ? 8'hEE : 8'h00;
  assign rx_req      = active_q && (state_q inside {S_IDLE, S_ADDR, S_WDATA, S_DRAIN});
`else
  assign status_byte = 8'h00;
  assign rx_req      = active_q && (state_q inside {S_IDLE, S_ADDR, S_WDATA});
`endif

  assign rx_take    = rx_req && bus.rx_fifo_rd_data_valid;
  assign tx_take    = (state_q inside {S_RDTX, S_STATUS}) && bus.tx_fifo_wr_data_req;
  assign last_abyte = (byte_cnt_q == 4'(ABYTES - 1));
  assign last_dbyte = (byte_cnt_q == 4'(BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rx_take) state_d = S_ADDR;
      S_ADDR:   if (rx_take && last_abyte) state_d = is_wr_q ? S_WDATA : S_SETUP;
      S_WDATA:  if (rx_take && last_dbyte) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.p_rdy) begin
          if (!is_wr_q)            state_d = S_RDTX;
          else if (beats_q == 7'd0) state_d = S_STATUS;
          else                     state_d = S_WDATA;
        end
`ifdef PGR_APB_CTR_TIMEOUT_EN
        else if (timeout) begin
          state_d = (is_wr_q && beats_q != 7'd0) ? S_DRAIN : S_STATUS;
        end
`endif
      end
      S_RDTX:   if (tx_take && last_dbyte) state_d = (beats_q == 7'd0) ? S_STATUS : S_SETUP;
      S_STATUS: if (tx_take) state_d = S_IDLE;
`ifdef PGR_APB_CTR_TIMEOUT_EN
      S_DRAIN:  if (rx_take && drain_q == 11'd1) state_d = S_STATUS;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Beats count down from hdr[6:0]; a frame ends when a beat completes with the counter at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      is_wr_q    <= 1'b0;
      beats_q    <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef PGR_APB_CTR_TIMEOUT_EN
      to_cnt_q   <= '0;
      drain_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      active_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (rx_take) begin
            is_wr_q    <= bus.rx_fifo_rd_data[7];
            beats_q    <= bus.rx_fifo_rd_data[6:0];
            byte_cnt_q <= '0;
`ifdef PGR_APB_CTR_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
          end
        end
        S_ADDR: begin
          if (rx_take) begin
            addr_q     <= ADDR_W'({addr_q, bus.rx_fifo_rd_data});
            byte_cnt_q <= last_abyte ? 4'd0 : byte_cnt_q + 4'd1;
          end
        end
        S_WDATA: begin
          if (rx_take) begin
            wdata_q    <= DATA_W'({wdata_q, bus.rx_fifo_rd_data});
            byte_cnt_q <= last_dbyte ? 4'd0 : byte_cnt_q + 4'd1;
          end
        end
        S_SETUP: begin
`ifdef PGR_APB_CTR_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        S_ACCESS: begin
          if (bus.p_rdy) begin
            addr_q     <= addr_q + ADDR_W'(BYTES);
            byte_cnt_q <= '0;
            if (!is_wr_q) rdata_q <= bus.p_rdata;
            if (is_wr_q && beats_q != 7'd0) beats_q <= beats_q - 7'd1;
          end
`ifdef PGR_APB_CTR_TIMEOUT_EN
          else if (timeout) begin
            err_q   <= 1'b1;
            drain_q <= 11'(beats_q) * 11'(BYTES);
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        S_RDTX: begin
          if (tx_take) begin
            rdata_q    <= DATA_W'({rdata_q, 8'h00});
            byte_cnt_q <= last_dbyte ? 4'd0 : byte_cnt_q + 4'd1;
            if (last_dbyte && beats_q != 7'd0) beats_q <= beats_q - 7'd1;
          end
        end
`ifdef PGR_APB_CTR_TIMEOUT_EN
        S_DRAIN: begin
          if (rx_take) drain_q <= drain_q - 11'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.rx_fifo_rd_data_req   = rx_req;
  assign bus.tx_fifo_wr_data_valid = tx_take;
  assign bus.tx_fifo_wr_data       = (state_q == S_STATUS) ? status_byte :
                                     (state_q == S_RDTX)   ? rdata_q[DATA_W-1 -: 8] : 8'h00;
  assign bus.p_sel                 = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.p_ce                  = (state_q == S_ACCESS);
  assign bus.p_we                  = bus.p_sel && is_wr_q;
  assign bus.p_addr                = addr_q;
  assign bus.p_wdata               = wdata_q;
  assign bus.p_strb                = {BYTES{bus.p_sel && is_wr_q}};
endmodule
